// File: rtl/lcd_spi_pkg.sv
// Shared opcodes, decoder state encoding and panel defaults for the LCD SPI receiver.
package lcd_spi_pkg;

    localparam int unsigned COORD_W   = 9;
    localparam int unsigned LCD_W_DEF = 240;
    localparam int unsigned LCD_H_DEF = 320;

    localparam logic [7:0] OP_CASET = 8'h2A;
    localparam logic [7:0] OP_RASET = 8'h2B;
    localparam logic [7:0] OP_RAMWR = 8'h2C;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_CASET,
        ST_RASET,
        ST_RAMWR_HI,
        ST_RAMWR_LO,
        ST_SKIP
    } state_e;

    // End coordinates past the panel edge saturate to the last valid pixel.
    function automatic logic [COORD_W-1:0] clamp_end(input logic [15:0] v, input int unsigned lim);
        if (v >= 16'(lim)) begin
            return COORD_W'(lim - 1);
        end
        return v[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/lcd_spi_deser.sv
// Synchronizes the async SPI pins into the system clock domain and assembles MSB-first bytes.
module lcd_spi_deser #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       cs,
    input  logic       dc,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_dc,
    output logic       abort
);

    // Bit lanes of each synchronizer stage: {dc, cs, mosi, sclk}; idle is cs high, sclk low.
    localparam logic [3:0] SYNC_IDLE = 4'b0100;

    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] sync_d [SYNC_STAGES];
    logic [3:0] pins_s;
    logic       sclk_prev_q, sclk_prev_d;
    logic       cs_prev_q, cs_prev_d;
    logic [6:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;
    logic       byte_valid_q, byte_valid_d;
    logic [7:0] byte_data_q, byte_data_d;
    logic       byte_dc_q, byte_dc_d;
    logic       abort_q, abort_d;
    logic       sclk_rise, cs_rise;

    always_comb begin
        sync_d[0] = {dc, cs, mosi, sclk};
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
        pins_s       = sync_q[SYNC_STAGES-1];
        sclk_rise    = pins_s[0] & ~sclk_prev_q;
        cs_rise      = pins_s[2] & ~cs_prev_q;
        sclk_prev_d  = pins_s[0];
        cs_prev_d    = pins_s[2];
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        byte_valid_d = 1'b0;
        byte_data_d  = byte_data_q;
        byte_dc_d    = byte_dc_q;
        abort_d      = 1'b0;
        if (cs_rise) begin
            abort_d = (cnt_q != 3'd0);
            cnt_d   = 3'd0;
        end else if (!pins_s[2] && sclk_rise) begin
            shift_d = {shift_q[5:0], pins_s[1]};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                byte_valid_d = 1'b1;
                byte_data_d  = {shift_q, pins_s[1]};
                byte_dc_d    = pins_s[3];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= SYNC_IDLE;
            end
            sclk_prev_q  <= 1'b0;
            cs_prev_q    <= 1'b1;
            shift_q      <= '0;
            cnt_q        <= '0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= '0;
            byte_dc_q    <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_d[i];
            end
            sclk_prev_q  <= sclk_prev_d;
            cs_prev_q    <= cs_prev_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            byte_dc_q    <= byte_dc_d;
            abort_q      <= abort_d;
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign byte_dc    = byte_dc_q;
    assign abort      = abort_q;

endmodule

// File: rtl/lcd_spi_rx.sv
// LCD SPI receiver: decodes CASET/RASET/RAMWR into windowed pixel writes.
// Define LCD_SPI_RX_CHECKSUM_EN to enable the per-frame pixel checksum on frame_sum.
module lcd_spi_rx
    import lcd_spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LCD_W       = LCD_W_DEF,
    parameter int unsigned LCD_H       = LCD_H_DEF
) (
    input  logic        sys_clk_50MHz,
    input  logic        sys_rst,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    input  logic        spi_cs,
    input  logic        spi_dc,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        pix_valid,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [15:0] pix_rgb,
    output logic        frame_done,
    output logic        rx_err,
    output logic [15:0] frame_sum
);

    logic               byte_valid;
    logic [7:0]         byte_data;
    logic               byte_dc;
    logic               abort;

    state_e             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [COORD_W-1:0] start_q, start_d;
    logic [7:0]         endh_q, endh_d;
    logic [COORD_W-1:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [7:0]         hi_q, hi_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic [7:0]         cmd_byte_q, cmd_byte_d;
    logic               pix_valid_q, pix_valid_d;
    logic [COORD_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [15:0]        pix_rgb_q, pix_rgb_d;
    logic               frame_done_q, frame_done_d;
    logic               rx_err_q, rx_err_d;
    logic [COORD_W-1:0] end_c, start_c;

    lcd_spi_deser #(.SYNC_STAGES(SYNC_STAGES)) u_deser (
        .clk        (sys_clk_50MHz),
        .rst        (sys_rst),
        .sclk       (spi_sclk),
        .mosi       (spi_mosi),
        .cs         (spi_cs),
        .dc         (spi_dc),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_dc    (byte_dc),
        .abort      (abort)
    );

    // Command/parameter decoder; commands preempt any state, data bytes follow the state.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        start_d      = start_q;
        endh_d       = endh_q;
        xs_d         = xs_q;
        xe_d         = xe_q;
        ys_d         = ys_q;
        ye_d         = ye_q;
        x_d          = x_q;
        y_d          = y_q;
        hi_d         = hi_q;
        cmd_valid_d  = 1'b0;
        cmd_byte_d   = cmd_byte_q;
        pix_valid_d  = 1'b0;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_rgb_d    = pix_rgb_q;
        frame_done_d = 1'b0;
        rx_err_d     = abort;
        end_c        = '0;
        start_c      = '0;
        if (byte_valid && !byte_dc) begin
            cmd_valid_d = 1'b1;
            cmd_byte_d  = byte_data;
            idx_d       = 2'd0;
            case (byte_data)
                OP_CASET: state_d = ST_CASET;
                OP_RASET: state_d = ST_RASET;
                OP_RAMWR: begin
                    state_d = ST_RAMWR_HI;
                    x_d     = xs_q;
                    y_d     = ys_q;
                end
                default:  state_d = ST_SKIP;
            endcase
        end else if (byte_valid) begin
            case (state_q)
                ST_CASET, ST_RASET: begin
                    idx_d = idx_q + 2'd1;
                    case (idx_q)
                        2'd0:    start_d[COORD_W-1] = byte_data[0];
                        2'd1:    start_d[7:0] = byte_data;
                        2'd2:    endh_d = byte_data;
                        default: begin
                            end_c   = clamp_end({endh_q, byte_data},
                                                (state_q == ST_CASET) ? LCD_W : LCD_H);
                            start_c = (start_q > end_c) ? end_c : start_q;
                            if (state_q == ST_CASET) begin
                                xs_d = start_c;
                                xe_d = end_c;
                            end else begin
                                ys_d = start_c;
                                ye_d = end_c;
                            end
                            state_d = ST_CMD;
                        end
                    endcase
                end
                ST_RAMWR_HI: begin
                    hi_d    = byte_data;
                    state_d = ST_RAMWR_LO;
                end
                ST_RAMWR_LO: begin
                    pix_valid_d = 1'b1;
                    pix_x_d     = x_q;
                    pix_y_d     = y_q;
                    pix_rgb_d   = {hi_q, byte_data};
                    state_d     = ST_RAMWR_HI;
                    if (x_q == xe_q) begin
                        x_d = xs_q;
                        if (y_q == ye_q) begin
                            y_d          = ys_q;
                            frame_done_d = 1'b1;
                        end else begin
                            y_d = y_q + COORD_W'(1);
                        end
                    end else begin
                        x_d = x_q + COORD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk_50MHz) begin
        if (sys_rst) begin
            state_q      <= ST_CMD;
            idx_q        <= '0;
            start_q      <= '0;
            endh_q       <= '0;
            xs_q         <= '0;
            xe_q         <= COORD_W'(LCD_W - 1);
            ys_q         <= '0;
            ye_q         <= COORD_W'(LCD_H - 1);
            x_q          <= '0;
            y_q          <= '0;
            hi_q         <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_byte_q   <= '0;
            pix_valid_q  <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_rgb_q    <= '0;
            frame_done_q <= 1'b0;
            rx_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            start_q      <= start_d;
            endh_q       <= endh_d;
            xs_q         <= xs_d;
            xe_q         <= xe_d;
            ys_q         <= ys_d;
            ye_q         <= ye_d;
            x_q          <= x_d;
            y_q          <= y_d;
            hi_q         <= hi_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_byte_q   <= cmd_byte_d;
            pix_valid_q  <= pix_valid_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_rgb_q    <= pix_rgb_d;
            frame_done_q <= frame_done_d;
            rx_err_q     <= rx_err_d;
        end
    end

`ifdef LCD_SPI_RX_CHECKSUM_EN
    logic [15:0] acc_q, acc_d;
    logic [15:0] frame_sum_q, frame_sum_d;

    // Running sum restarts on each RAMWR and after the last pixel of a window.
    always_comb begin
        acc_d       = acc_q;
        frame_sum_d = frame_sum_q;
        if (pix_valid_d && frame_done_d) begin
            frame_sum_d = acc_q + pix_rgb_d;
            acc_d       = '0;
        end else if (pix_valid_d) begin
            acc_d = acc_q + pix_rgb_d;
        end else if (cmd_valid_d && cmd_byte_d == OP_RAMWR) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge sys_clk_50MHz) begin
        if (sys_rst) begin
            acc_q       <= '0;
            frame_sum_q <= '0;
        end else begin
            acc_q       <= acc_d;
            frame_sum_q <= frame_sum_d;
        end
    end

    assign frame_sum = frame_sum_q;
`else
    assign frame_sum = '0;
`endif

    assign cmd_valid  = cmd_valid_q;
    assign cmd_byte   = cmd_byte_q;
    assign pix_valid  = pix_valid_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign pix_rgb    = pix_rgb_q;
    assign frame_done = frame_done_q;
    assign rx_err     = rx_err_q;

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Directed self-checking bench for lcd_spi_rx; pulses are logged on the falling clock edge.
module tb_lcd_spi_rx;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        spi_sclk, spi_mosi, spi_cs, spi_dc;
    logic        cmd_valid, pix_valid, frame_done, rx_err;
    logic [7:0]  cmd_byte;
    logic [8:0]  pix_x, pix_y;
    logic [15:0] pix_rgb, frame_sum;

    int checks = 0;
    int errors = 0;

    logic [7:0]  cmd_log [$];
    logic [34:0] pix_log [$];
    int          err_cnt  = 0;
    int          stray_fd = 0;

    lcd_spi_rx #(.SYNC_STAGES(2), .LCD_W(240), .LCD_H(320)) dut (
        .sys_clk_50MHz (clk),
        .sys_rst       (sys_rst),
        .spi_sclk      (spi_sclk),
        .spi_mosi      (spi_mosi),
        .spi_cs        (spi_cs),
        .spi_dc        (spi_dc),
        .cmd_valid     (cmd_valid),
        .cmd_byte      (cmd_byte),
        .pix_valid     (pix_valid),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .pix_rgb       (pix_rgb),
        .frame_done    (frame_done),
        .rx_err        (rx_err),
        .frame_sum     (frame_sum)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_valid === 1'b1) cmd_log.push_back(cmd_byte);
        if (pix_valid === 1'b1) pix_log.push_back({frame_done, pix_x, pix_y, pix_rgb});
        if (rx_err === 1'b1) err_cnt++;
        if (frame_done === 1'b1 && pix_valid !== 1'b1) stray_fd++;
    end

    task automatic spi_bits(input logic dc, input logic [7:0] b, input int nbits);
        spi_dc = dc;
        spi_cs = 1'b0;
        #100;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = b[7-i];
            #100 spi_sclk = 1'b1;
            #100 spi_sclk = 1'b0;
        end
        #100 spi_cs = 1'b1;
        #200;
    endtask

    task automatic cmd(input logic [7:0] b);
        spi_bits(1'b0, b, 8);
    endtask

    task automatic dat(input logic [7:0] b);
        spi_bits(1'b1, b, 8);
    endtask

    task automatic pixel(input logic [15:0] v);
        dat(v[15:8]);
        dat(v[7:0]);
    endtask

    task automatic do_reset;
        sys_rst  = 1'b1;
        spi_cs   = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        spi_dc   = 1'b0;
        repeat (3) @(posedge clk);
        #1 sys_rst = 1'b0;
        #100;
    endtask

    task automatic test_reset;
        sys_rst = 1'b1;
        spi_cs = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_dc = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({cmd_valid, pix_valid, frame_done, rx_err} !== 4'b0000) begin
            errors++; $display("FAIL reset_pulses: got %b exp 0000", {cmd_valid, pix_valid, frame_done, rx_err});
        end
        checks++;
        if ({cmd_byte, pix_x, pix_y, pix_rgb, frame_sum} !== 58'd0) begin
            errors++; $display("FAIL reset_values: got %h exp 0", {cmd_byte, pix_x, pix_y, pix_rgb, frame_sum});
        end
        sys_rst = 1'b0;
        #100;
    endtask

    task automatic test_cmd;
        int cb, pb;
        cb = cmd_log.size(); pb = pix_log.size();
        cmd(8'h11);
        checks++;
        if (cmd_log.size() - cb !== 1) begin
            errors++; $display("FAIL cmd11_count: got %0d exp 1", cmd_log.size() - cb);
        end
        checks++;
        if (cmd_byte !== 8'h11) begin
            errors++; $display("FAIL cmd11_byte: got %h exp 11", cmd_byte);
        end
        checks++;
        if (pix_log.size() !== pb) begin
            errors++; $display("FAIL cmd11_no_pix: got %0d exp 0", pix_log.size() - pb);
        end
    endtask

    task automatic test_data_ignored;
        int pb;
        pb = pix_log.size();
        dat(8'h55); dat(8'h66);
        do_reset();
        dat(8'h77); dat(8'h88);
        checks++;
        if (pix_log.size() !== pb) begin
            errors++; $display("FAIL data_ignored: got %0d pixels exp 0", pix_log.size() - pb);
        end
    endtask

    task automatic test_latency;
        logic [7:0] b;
        int n;
        b = 8'h3A;
        n = 0;
        spi_dc = 1'b0; spi_cs = 1'b0;
        #100;
        for (int i = 0; i < 7; i++) begin
            spi_mosi = b[7-i];
            #100 spi_sclk = 1'b1;
            #100 spi_sclk = 1'b0;
        end
        spi_mosi = b[0];
        #100;
        @(posedge clk);
        #5 spi_sclk = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (n == 0 && cmd_valid === 1'b1) n = k;
        end
        checks++;
        if (n !== 4) begin
            errors++; $display("FAIL cmd_latency: got %0d clocks exp 4", n);
        end
        spi_sclk = 1'b0;
        #100 spi_cs = 1'b1;
        #200;
        checks++;
        if (cmd_byte !== 8'h3A) begin
            errors++; $display("FAIL latency_byte: got %h exp 3a", cmd_byte);
        end
    endtask

    task automatic test_ramwr_basic;
        int pb;
        logic [34:0] exp_p [2];
        exp_p[0] = {1'b0, 9'd0, 9'd0, 16'hF800};
        exp_p[1] = {1'b0, 9'd1, 9'd0, 16'h1234};
        do_reset();
        pb = pix_log.size();
        cmd(8'h2C);
        dat(8'hF8); dat(8'h00);
        pixel(16'h1234);
        checks++;
        if (pix_log.size() - pb !== 2) begin
            errors++; $display("FAIL ramwr_count: got %0d exp 2", pix_log.size() - pb);
        end
        for (int i = 0; i < 2 && pb + i < pix_log.size(); i++) begin
            checks++;
            if (pix_log[pb+i] !== exp_p[i]) begin
                errors++; $display("FAIL ramwr_pix%0d: got %h exp %h", i, pix_log[pb+i], exp_p[i]);
            end
        end
        #400;
        checks++;
        if (pix_rgb !== 16'h1234 || pix_x !== 9'd1) begin
            errors++; $display("FAIL ramwr_hold: got rgb %h x %0d exp 1234 x 1", pix_rgb, pix_x);
        end
    endtask

    task automatic test_window;
        int pb;
        logic [34:0] exp_p [5];
        exp_p[0] = {1'b0, 9'd100, 9'd50, 16'h1111};
        exp_p[1] = {1'b0, 9'd101, 9'd50, 16'h2222};
        exp_p[2] = {1'b0, 9'd100, 9'd51, 16'h3333};
        exp_p[3] = {1'b1, 9'd101, 9'd51, 16'h4444};
        exp_p[4] = {1'b0, 9'd100, 9'd50, 16'h5555};
        do_reset();
        cmd(8'h2A); dat(8'h00); dat(8'd100); dat(8'h00); dat(8'd101);
        cmd(8'h2B); dat(8'h00); dat(8'd50);  dat(8'h00); dat(8'd51);
        pb = pix_log.size();
        cmd(8'h2C);
        pixel(16'h1111); pixel(16'h2222); pixel(16'h3333); pixel(16'h4444); pixel(16'h5555);
        checks++;
        if (pix_log.size() - pb !== 5) begin
            errors++; $display("FAIL window_count: got %0d exp 5", pix_log.size() - pb);
        end
        for (int i = 0; i < 5 && pb + i < pix_log.size(); i++) begin
            checks++;
            if (pix_log[pb+i] !== exp_p[i]) begin
                errors++; $display("FAIL window_pix%0d: got %h exp %h", i, pix_log[pb+i], exp_p[i]);
            end
        end
        checks++;
        if (stray_fd !== 0) begin
            errors++; $display("FAIL frame_done_alone: got %0d exp 0", stray_fd);
        end
    endtask

    task automatic test_abort;
        int cb, eb;
        do_reset();
        cb = cmd_log.size(); eb = err_cnt;
        spi_bits(1'b0, 8'hA0, 5);
        checks++;
        if (err_cnt - eb !== 1) begin
            errors++; $display("FAIL abort_err: got %0d exp 1", err_cnt - eb);
        end
        spi_cs = 1'b0; #200; spi_cs = 1'b1; #200;
        cmd(8'h2A);
        checks++;
        if (err_cnt - eb !== 1) begin
            errors++; $display("FAIL abort_empty_cs: got %0d exp 1", err_cnt - eb);
        end
        checks++;
        if (cmd_log.size() - cb !== 1 || cmd_byte !== 8'h2A) begin
            errors++; $display("FAIL abort_resync: got %0d cmds byte %h exp 1 byte 2a", cmd_log.size() - cb, cmd_byte);
        end
    endtask

    task automatic test_clamp;
        int pb;
        logic [34:0] exp_p [3];
        exp_p[0] = {1'b0, 9'd238, 9'd5, 16'hA001};
        exp_p[1] = {1'b1, 9'd239, 9'd5, 16'hA002};
        exp_p[2] = {1'b0, 9'd238, 9'd5, 16'hA003};
        do_reset();
        cmd(8'h2A); dat(8'h00); dat(8'hEE); dat(8'h01); dat(8'hF4);
        cmd(8'h2B); dat(8'h00); dat(8'h05); dat(8'h00); dat(8'h05);
        pb = pix_log.size();
        cmd(8'h2C);
        pixel(16'hA001); pixel(16'hA002); pixel(16'hA003);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pb + i >= pix_log.size()) begin
                errors++; $display("FAIL clamp_pix%0d: got none exp %h", i, exp_p[i]);
            end else if (pix_log[pb+i] !== exp_p[i]) begin
                errors++; $display("FAIL clamp_pix%0d: got %h exp %h", i, pix_log[pb+i], exp_p[i]);
            end
        end
    endtask

    task automatic test_start_gt_end;
        int pb;
        logic [34:0] exp_p [3];
        exp_p[0] = {1'b0, 9'd10, 9'd0, 16'h0B01};
        exp_p[1] = {1'b1, 9'd10, 9'd1, 16'h0B02};
        exp_p[2] = {1'b0, 9'd10, 9'd0, 16'h0B03};
        do_reset();
        cmd(8'h2A); dat(8'h01); dat(8'h00); dat(8'h00); dat(8'h0A);
        cmd(8'h2B); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h01);
        pb = pix_log.size();
        cmd(8'h2C);
        pixel(16'h0B01); pixel(16'h0B02); pixel(16'h0B03);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pb + i >= pix_log.size()) begin
                errors++; $display("FAIL start_gt_end_pix%0d: got none exp %h", i, exp_p[i]);
            end else if (pix_log[pb+i] !== exp_p[i]) begin
                errors++; $display("FAIL start_gt_end_pix%0d: got %h exp %h", i, pix_log[pb+i], exp_p[i]);
            end
        end
    endtask

    task automatic test_reset_midbyte;
        int cb, eb;
        eb = err_cnt;
        spi_dc = 1'b0; spi_cs = 1'b0;
        #100;
        for (int i = 0; i < 4; i++) begin
            spi_mosi = 1'b1;
            #100 spi_sclk = 1'b1;
            #100 spi_sclk = 1'b0;
        end
        sys_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({cmd_byte, pix_x, pix_rgb} !== 33'd0) begin
            errors++; $display("FAIL midbyte_reset_vals: got %h exp 0", {cmd_byte, pix_x, pix_rgb});
        end
        sys_rst = 1'b0;
        #200 spi_cs = 1'b1;
        #200;
        cb = cmd_log.size();
        cmd(8'h2A);
        checks++;
        if (err_cnt !== eb) begin
            errors++; $display("FAIL midbyte_no_err: got %0d exp 0", err_cnt - eb);
        end
        checks++;
        if (cmd_log.size() - cb !== 1 || cmd_byte !== 8'h2A) begin
            errors++; $display("FAIL midbyte_resync: got %0d cmds byte %h exp 1 byte 2a", cmd_log.size() - cb, cmd_byte);
        end
    endtask

    task automatic test_checksum;
        logic [15:0] exp_sum;
        do_reset();
        cmd(8'h2A); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h01);
        cmd(8'h2B); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h00);
        cmd(8'h2C);
        pixel(16'hFFFF); pixel(16'h0002);
`ifdef LCD_SPI_RX_CHECKSUM_EN
        exp_sum = 16'h0001;
`else
        exp_sum = 16'h0000;
`endif
        checks++;
        if (frame_sum !== exp_sum) begin
            errors++; $display("FAIL checksum: got %h exp %h", frame_sum, exp_sum);
        end
        checks++;
        if (pix_log.size() == 0 || pix_log[pix_log.size()-1] !== {1'b1, 9'd1, 9'd0, 16'h0002}) begin
            errors++; $display("FAIL checksum_last_pix: got %0d entries exp last 1_001_000_0002", pix_log.size());
        end
    endtask

    initial begin
        test_reset();
        test_cmd();
        test_data_ignored();
        test_latency();
        test_ramwr_basic();
        test_window();
        test_abort();
        test_clamp();
        test_start_gt_end();
        test_reset_midbyte();
        test_checksum();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
